sgpr_wr_arbiter: RTL

SGPR_WR_ARBITER -- requirements
Module: sgpr_wr_arbiter

---
 rtl/sgpr_wr_arbiter_pkg.sv | 26 ++
 rtl/sgpr_wr_arbiter_rr.sv | 30 +++
 rtl/sgpr_wr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sgpr_wr_arbiter_pkg.sv
// Shared definitions for the SGPR write arbiter.
//   Requester indices (SALU/LSU/VALU), requester count, datapath widths,
//   the buffered write-entry struct and a mod-3 index increment helper.
package sgpr_wr_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 64;
    localparam int WSEL_W  = 2;

    localparam logic [1:0] REQ_SALU = 2'd0;
    localparam logic [1:0] REQ_LSU  = 2'd1;
    localparam logic [1:0] REQ_VALU = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [WSEL_W-1:0] wordsel;
    } wr_entry_t;

    // (idx + 1) mod NUM_REQ for a 2-bit requester index.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/sgpr_wr_arbiter_rr.sv
// Three-way round-robin picker.
//   valid_i   : requesters with a buffered write
//   pointer_i : index where the search starts (highest priority)
//   grant_o   : one-hot grant, all zero when nothing is valid
module rr_arbiter_3
    import sgpr_wr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         pointer_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        // An out-of-range pointer (3) behaves like 0 so the picker never stalls.
        idx     = (pointer_i > 2'(NUM_REQ - 1)) ? 2'd0 : pointer_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/sgpr_wr_arbiter.sv
// Arbitrates SALU/LSU/VALU write requests onto the single SGPR write port.
//   clk, rst                 : clock, synchronous active-high reset
//   <src>_req/addr/data/wordsel : write request per source (SALU, LSU, VALU)
//   <src>_hold               : source must not issue a new request
//   sgpr_wr_en/addr/data     : registered write port, wr_en per 32-bit word
//   pending                  : capture-buffer valid flags {VALU, LSU, SALU}
// Each source has a one-entry capture buffer. A round-robin pick drains one
// buffer per cycle; the granted entry appears on the write port next cycle.
module sgpr_wr_arbiter
    import sgpr_wr_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              salu_req,
    input  logic [ADDR_W-1:0] salu_addr,
    input  logic [DATA_W-1:0] salu_data,
    input  logic [WSEL_W-1:0] salu_wordsel,

    input  logic              lsu_req,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic [WSEL_W-1:0] lsu_wordsel,

    input  logic              valu_req,
    input  logic [ADDR_W-1:0] valu_addr,
    input  logic [DATA_W-1:0] valu_data,
    input  logic [WSEL_W-1:0] valu_wordsel,

    output logic              salu_hold,
    output logic              lsu_hold,
    output logic              valu_hold,

    output logic [WSEL_W-1:0] sgpr_wr_en,
    output logic [ADDR_W-1:0] sgpr_wr_addr,
    output logic [DATA_W-1:0] sgpr_wr_data,

    output logic [NUM_REQ-1:0] pending
);

    logic      [NUM_REQ-1:0] req;
    wr_entry_t [NUM_REQ-1:0] in_ent;

    logic      [NUM_REQ-1:0] valid_q, valid_d;
    wr_entry_t [NUM_REQ-1:0] ent_q, ent_d;
    logic      [1:0]         ptr_q, ptr_d;

    logic      [NUM_REQ-1:0] grant;
    logic      [NUM_REQ-1:0] hold;
    logic      [NUM_REQ-1:0] accept;
    logic                    gnt_any;
    logic      [1:0]         gnt_idx;

    logic [WSEL_W-1:0] wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    assign req              = {valu_req, lsu_req, salu_req};
    assign in_ent[REQ_SALU] = '{addr: salu_addr, data: salu_data, wordsel: salu_wordsel};
    assign in_ent[REQ_LSU]  = '{addr: lsu_addr,  data: lsu_data,  wordsel: lsu_wordsel};
    assign in_ent[REQ_VALU] = '{addr: valu_addr, data: valu_data, wordsel: valu_wordsel};

    rr_arbiter_3 u_rr (
        .valid_i   (valid_q),
        .pointer_i (ptr_q),
        .grant_o   (grant)
    );

    // A buffer being drained this cycle frees itself, so its source may
    // present the next write immediately (one write per cycle per source).
    assign hold      = rst ? '0 : (valid_q & ~grant);
    assign pending   = rst ? '0 : valid_q;
    assign salu_hold = hold[REQ_SALU];
    assign lsu_hold  = hold[REQ_LSU];
    assign valu_hold = hold[REQ_VALU];

    always_comb begin
        gnt_any = |grant;
        gnt_idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = 2'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        accept  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // wordsel==0 writes nothing, so it is never buffered.
            accept[i] = req[i] && (in_ent[i].wordsel != '0) && !hold[i];
            if (grant[i]) valid_d[i] = 1'b0;
            if (accept[i]) begin
                valid_d[i] = 1'b1;
                ent_d[i]   = in_ent[i];
            end
        end
    end

    always_comb begin
        ptr_d     = gnt_any ? next_idx(gnt_idx) : ptr_q;
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (gnt_any) begin
            wr_en_d   = ent_q[gnt_idx].wordsel;
            wr_addr_d = ent_q[gnt_idx].addr;
            wr_data_d = ent_q[gnt_idx].data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            ent_q     <= '0;
            ptr_q     <= REQ_SALU;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ent_q     <= ent_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign sgpr_wr_en   = wr_en_q;
    assign sgpr_wr_addr = wr_addr_q;
    assign sgpr_wr_data = wr_data_q;

endmodule
